// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared types and helpers for the CPU I/O port bridge.
//   irq_state_e   : interrupt FSM states (IDLE, PULSE, ARMED)
//   STAT_*        : bit positions inside the 4-bit status word
//   ptr_w/cnt_w   : FIFO pointer width (log2 DEPTH) and count width (log2 DEPTH + 1)
package io_bridge_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_PULSE = 2'd1,
    IRQ_ARMED = 2'd2
  } irq_state_e;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_UNF   = 2;
  localparam int STAT_TX_OVF   = 3;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: single-clock show-ahead FIFO.
//   clk, reset     : clock, synchronous active-high reset (pointers/count only)
//   push, wdata    : write request and data; accepted when not full or when a pop happens the same edge
//   pop            : read request; ignored when empty
//   rdata          : head entry (show-ahead), valid whenever !empty
//   full, empty    : occupancy flags derived from the registered count
//   count          : number of stored entries, 0..DEPTH
module io_sync_fifo
  import io_bridge_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 8,
  localparam int PTR_W  = ptr_w(DEPTH),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a full FIFO can still take the push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only and is never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: external-side peripheral of the 8-bit CPU I/O port.
//   CPU side    : cpu_data_out/cpu_wr push the TX FIFO, cpu_rd pops the RX FIFO,
//                 data_in shows the RX head (8'h00 when empty), interrupt is a registered one-cycle pulse.
//   Device side : ext_rx_data/valid/ready feed the RX FIFO, ext_tx_data/valid/ready drain the TX FIFO.
//   status      : {tx_ovf, rx_unf, tx_full, rx_empty}; status_clr clears the two sticky error bits.
// Optional build macro IO_IRQ_TIMEOUT_EN: while the interrupt FSM is ARMED and the CPU does not read,
// a further pulse is issued every TIMEOUT cycles.
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int IRQ_THRESHOLD = 1,
  parameter int TIMEOUT       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_data_out,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  output logic [7:0] data_in,
  output logic       interrupt,
  input  logic [7:0] ext_rx_data,
  input  logic       ext_rx_valid,
  output logic       ext_rx_ready,
  output logic [7:0] ext_tx_data,
  output logic       ext_tx_valid,
  input  logic       ext_tx_ready,
  output logic [3:0] status,
  input  logic       status_clr
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [7:0]       rx_head;
  logic             rx_full;
  logic             rx_empty;
  logic [CNT_W-1:0] rx_count;
  logic             tx_full;
  logic             tx_empty;
  logic [CNT_W-1:0] tx_count;
  logic             rx_push;
  logic             tx_pop;
  logic             tx_ovf;
  logic             rx_unf;
  logic             irq_cond;
  irq_state_e       irq_state;
  logic             unused_tx_count;

  // Device-side handshakes depend only on registered FIFO counts.
  assign ext_rx_ready = !rx_full;
  assign ext_tx_valid = !tx_empty;
  assign rx_push      = ext_rx_valid && ext_rx_ready;
  assign tx_pop       = ext_tx_valid && ext_tx_ready;
  assign data_in      = rx_empty ? 8'h00 : rx_head;
  assign irq_cond     = (rx_count >= CNT_W'(IRQ_THRESHOLD));
  assign unused_tx_count = ^tx_count;

  always_comb begin
    status                = '0;
    status[STAT_TX_OVF]   = tx_ovf;
    status[STAT_RX_UNF]   = rx_unf;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_RX_EMPTY] = rx_empty;
  end

  io_sync_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (ext_rx_data),
    .pop   (cpu_rd),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  io_sync_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cpu_wr),
    .wdata (cpu_data_out),
    .pop   (tx_pop),
    .rdata (ext_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // Sticky errors: a new error on the same edge as status_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (cpu_wr && tx_full && !tx_pop) tx_ovf <= 1'b1;
      else if (status_clr)              tx_ovf <= 1'b0;
      if (cpu_rd && rx_empty)           rx_unf <= 1'b1;
      else if (status_clr)              rx_unf <= 1'b0;
    end
  end

`ifdef IO_IRQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // The pulse is registered: it is high for the cycle the FSM spends in PULSE,
  // or for one cycle after a timeout expiry while ARMED.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_state <= IRQ_IDLE;
      interrupt <= 1'b0;
`ifdef IO_IRQ_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      interrupt <= 1'b0;
`ifdef IO_IRQ_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
      case (irq_state)
        IRQ_IDLE: begin
          if (irq_cond) begin
            irq_state <= IRQ_PULSE;
            interrupt <= 1'b1;
          end
        end
        IRQ_PULSE: irq_state <= IRQ_ARMED;
        IRQ_ARMED: begin
          if (!irq_cond) begin
            irq_state <= IRQ_IDLE;
          end else begin
`ifdef IO_IRQ_TIMEOUT_EN
            if (!cpu_rd) begin
              if (tmo_cnt == TMO_W'(TIMEOUT - 1)) interrupt <= 1'b1;
              else                                tmo_cnt   <= tmo_cnt + TMO_W'(1);
            end
`endif
          end
        end
        default: irq_state <= IRQ_IDLE;
      endcase
    end
  end

endmodule
